// File: rtl/clock_divide_if.sv
// Ratio-load handshake between the requester and the clock divider.
interface clock_divide_if #(
  parameter int CNT_WIDTH = 8
);
  logic [CNT_WIDTH-1:0] divide;
  logic                 divide_valid;
  logic                 divide_ready;

  modport master (output divide, output divide_valid, input divide_ready);
  modport slave  (input divide, input divide_valid, output divide_ready);
endinterface

// File: rtl/clock_divide.sv
// Programmable integer clock divider; ratio changes wait for a period boundary
// so the divided clock never carries a runt pulse.
module clock_divide #(
  parameter int CNT_WIDTH = 8
) (
  input  logic          base_clock,
  input  logic          reset,
  clock_divide_if.slave ctrl,
  output logic          divided_clock,
  output logic          divided_tick,
  output logic          locked
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  logic [1:0]           state, state_nx;
  logic [CNT_WIDTH-1:0] n_cur, n_cur_nx;
  logic [CNT_WIDTH-1:0] n_pend, n_pend_nx;
  logic [CNT_WIDTH-1:0] ph, ph_nx;
  logic                 ready_q;
  logic                 xfer;
  logic                 at_end;
  logic [CNT_WIDTH-1:0] req;

  function automatic logic [CNT_WIDTH-1:0] clamp_ratio(input logic [CNT_WIDTH-1:0] n);
    return (n == CNT_WIDTH'(1)) ? CNT_WIDTH'(2) : n;
  endfunction

  // Widened by one bit so (N+1)>>1 cannot wrap at the maximum ratio.
  function automatic logic high_phase(input logic [CNT_WIDTH-1:0] p,
                                      input logic [CNT_WIDTH-1:0] n);
    logic [CNT_WIDTH:0] half;
    half = ({1'b0, n} + (CNT_WIDTH+1)'(1)) >> 1;
    return {1'b0, p} < half;
  endfunction

  assign ctrl.divide_ready = ready_q;
  assign xfer   = ctrl.divide_valid && ready_q;
  assign at_end = (ph == n_cur - CNT_WIDTH'(1));
  assign req    = clamp_ratio(ctrl.divide);

  always_comb begin
    state_nx  = state;
    n_cur_nx  = n_cur;
    n_pend_nx = n_pend;
    ph_nx     = ph;
    case (state)
      IDLE: begin
        ph_nx = '0;
        if (xfer && req != '0) begin
          n_cur_nx = req;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (at_end) begin
          ph_nx = '0;
          if (xfer) begin
            if (req == '0) state_nx = IDLE;
            else           n_cur_nx = req;
          end
        end else begin
          ph_nx = ph + CNT_WIDTH'(1);
          if (xfer) begin
            n_pend_nx = req;
            state_nx  = SWITCH;
          end
        end
      end
      SWITCH: begin
        if (at_end) begin
          ph_nx = '0;
          if (n_pend != '0) begin
            n_cur_nx = n_pend;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          ph_nx = ph + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        ph_nx    = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with ph.
  always_ff @(posedge base_clock) begin
    if (!reset) begin
      state         <= IDLE;
      n_cur         <= '0;
      n_pend        <= '0;
      ph            <= '0;
      ready_q       <= 1'b0;
      divided_clock <= 1'b0;
      divided_tick  <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_nx;
      n_cur         <= n_cur_nx;
      n_pend        <= n_pend_nx;
      ph            <= ph_nx;
      ready_q       <= (state_nx != SWITCH);
      divided_clock <= (state_nx != IDLE) && high_phase(ph_nx, n_cur_nx);
      divided_tick  <= (state_nx != IDLE) && (ph_nx == '0);
      locked        <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_clock_divide.sv
// Self-checking bench for clock_divide: directed scenarios plus randomized
// traffic compared cycle by cycle against a period-level reference model.
module tb_clock_divide;

  logic base_clock = 1'b0;
  logic reset;
  logic divided_clock, divided_tick, locked;

  clock_divide_if #(.CNT_WIDTH(8)) bus();

  clock_divide #(.CNT_WIDTH(8)) dut (
    .base_clock    (base_clock),
    .reset         (reset),
    .ctrl          (bus),
    .divided_clock (divided_clock),
    .divided_tick  (divided_tick),
    .locked        (locked)
  );

  always #5 base_clock = ~base_clock;

  int checks = 0;
  int errors = 0;

  // Reference model: is the clock running, its ratio, cycles since the period
  // started, and an optional request waiting for the period to end.
  int m_run = 0, m_ratio = 0, m_pos = 0, m_pend_on = 0, m_pend = 0, m_rdy = 0;

  task automatic model_step(input bit r, input bit v, input int d);
    int req;
    bit acc, last;
    if (!r) begin
      m_run = 0; m_pos = 0; m_pend_on = 0; m_rdy = 0;
      return;
    end
    acc  = v && (m_rdy != 0);
    last = (m_run != 0) && (m_pos == m_ratio - 1);
    req  = (d == 1) ? 2 : d;
    if (m_run == 0) begin
      if (acc && req != 0) begin m_run = 1; m_ratio = req; m_pos = 0; end
    end else if (m_pend_on != 0) begin
      if (last) begin
        if (m_pend == 0) m_run = 0; else m_ratio = m_pend;
        m_pos = 0; m_pend_on = 0;
      end else m_pos++;
    end else if (acc && !last) begin
      m_pend_on = 1; m_pend = req; m_pos++;
    end else if (last) begin
      if (acc) begin
        if (req == 0) m_run = 0; else m_ratio = req;
      end
      m_pos = 0;
    end else m_pos++;
    m_rdy = (m_pend_on == 0);
  endtask

  function automatic logic [3:0] exp_vec();
    logic c, t, l;
    c = (m_run != 0) && (m_pos < (m_ratio + 1) / 2);
    t = (m_run != 0) && (m_pos == 0);
    l = (m_run != 0) && (m_pend_on == 0);
    return {c, t, l, logic'(m_rdy != 0)};
  endfunction

  function automatic logic [3:0] obs_vec();
    return {divided_clock, divided_tick, locked, bus.divide_ready};
  endfunction

  task automatic step(input bit r, input bit v, input int d);
    reset            = r;
    bus.divide_valid = v;
    bus.divide       = 8'(d);
    @(posedge base_clock);
    model_step(r, v, d);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 4);
    checks++;
    if (obs_vec() !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b want 0000", obs_vec());
    end
    step(1'b1, 1'b0, 0);
    checks++;
    if (obs_vec() !== 4'b0001 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %b want 0001 (model %b)", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_start();
    bit pat [4];
    pat = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    step(1'b1, 1'b1, 4);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL start_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      checks++;
      if (divided_clock !== pat[i % 4] || divided_tick !== (i % 4 == 0) || locked !== 1'b1) begin
        errors++; $display("FAIL start_pattern cyc %0d: got clk/tick/lock %b%b%b want %b%b1",
                           i, divided_clock, divided_tick, locked, pat[i % 4], (i % 4 == 0));
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_odd_clamp();
    int ratios [3];
    int periods [3];
    int highs_exp [3];
    int highs, ticks;
    ratios = '{5, 1, 255}; periods = '{5, 2, 255}; highs_exp = '{3, 1, 128};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      step(1'b1, 1'b1, ratios[k]);
      highs = 0; ticks = 0;
      for (int i = 0; i < periods[k]; i++) begin
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL odd_model N=%0d cyc %0d: got %b want %b", ratios[k], i, obs_vec(), exp_vec());
        end
        if (divided_clock === 1'b1) highs++;
        if (divided_tick === 1'b1) ticks++;
        step(1'b1, 1'b0, 0);
      end
      checks++;
      if (highs != highs_exp[k] || ticks != 1 || divided_tick !== 1'b1) begin
        errors++; $display("FAIL odd_duty N=%0d: got highs %0d ticks %0d next_tick %b want %0d 1 1",
                           ratios[k], highs, ticks, divided_tick, highs_exp[k]);
      end
    end
  endtask

  task automatic test_mid_change();
    do_reset();
    step(1'b1, 1'b1, 4);
    for (int i = 0; i < 8 && m_pos != 1; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 6);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (i < 2) begin
        checks++;
        if (bus.divide_ready !== 1'b0 || locked !== 1'b0) begin
          errors++; $display("FAIL mid_switch cyc %0d: got ready %b locked %b want 0 0", i, bus.divide_ready, locked);
        end
      end else if (i == 2 || i == 8) begin
        checks++;
        if (divided_tick !== 1'b1 || locked !== 1'b1 || divided_clock !== 1'b1) begin
          errors++; $display("FAIL mid_newperiod cyc %0d: got tick %b locked %b clk %b want 1 1 1",
                             i, divided_tick, locked, divided_clock);
        end
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(1'b1, 1'b1, 4);
    for (int i = 0; i < 8 && m_pos != 3; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== {(i % 2 == 0), (i % 2 == 0), 2'b11}) begin
        errors++; $display("FAIL boundary cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_stop();
    bit pat [3];
    pat = '{1'b1, 1'b0, 1'b0};
    do_reset();
    step(1'b1, 1'b1, 4);
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stop_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (i < 3) begin
        checks++;
        if (divided_clock !== pat[i]) begin
          errors++; $display("FAIL stop_finish cyc %0d: got clk %b want %b", i, divided_clock, pat[i]);
        end
      end else begin
        checks++;
        if (obs_vec() !== 4'b0001) begin
          errors++; $display("FAIL stop_idle cyc %0d: got %b want 0001", i, obs_vec());
        end
      end
      step(1'b1, 1'b0, 0);
    end
    step(1'b1, 1'b1, 3);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs_vec() !== exp_vec() || (i == 0 && obs_vec() !== 4'b1111)) begin
        errors++; $display("FAIL restart cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_reset_switch();
    do_reset();
    step(1'b1, 1'b1, 4);
    for (int i = 0; i < 8 && m_pos != 1; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 6);
    step(1'b0, 1'b0, 0);
    checks++;
    if (obs_vec() !== 4'b0000) begin
      errors++; $display("FAIL rst_switch: got %b want 0000", obs_vec());
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 0);
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== 4'b0001) begin
        errors++; $display("FAIL rst_switch_idle cyc %0d: got %b want 0001", i, obs_vec());
      end
    end
  endtask

  task automatic test_random();
    bit r, v;
    int d, sel;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 599) != 0);
      v   = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 11);
      if (sel == 0)       d = 0;
      else if (sel == 1)  d = 1;
      else if (sel == 11) d = $urandom_range(100, 255);
      else                d = $urandom_range(2, 12);
      step(r, v, d);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.divide_valid = 1'b0;
    bus.divide = '0;
    test_reset();
    test_start();
    test_odd_clamp();
    test_mid_change();
    test_boundary();
    test_stop();
    test_reset_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
